quick_sort_io_sequencer: RTL and testbench

- Front/back end of the quick-sort engine.
- Accepts an unsorted array as a valid/ready word stream and writes it into the register file at base_addr+k.
- Hands the range lo=0, hi=len-1 to the sort controller and waits for it to finish.
- Streams the sorted array back out as a valid/ready word stream. It owns the register-file port whenever the sort engine is not running.

---
 rtl/quick_sort_io_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_quick_sort_io_sequencer.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/quick_sort_io_sequencer.sv
// Load/sort/drain sequencer around the quick-sort engine's register file.
// Optional word-sum integrity check enabled by defining QS_IO_CHECKSUM_EN.
module quick_sort_io_sequencer #(
  parameter int WORD_SIZE = 16,
  parameter int MAX_LEN   = 32,
  parameter int LEN_W     = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_start,
  input  logic [WORD_SIZE-1:0] base_addr,
  input  logic [LEN_W-1:0]     len,
  input  logic [WORD_SIZE-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [WORD_SIZE-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last,
  output logic [WORD_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_wdata,
  input  logic [WORD_SIZE-1:0] mem_rdata,
  output logic                 mem_read_en,
  output logic                 mem_write_en,
  output logic                 mem_owner,
  output logic                 sort_start,
  output logic [WORD_SIZE-1:0] sort_lo,
  output logic [WORD_SIZE-1:0] sort_hi,
  input  logic                 sort_done,
  output logic                 busy,
  output logic                 err_len
`ifdef QS_IO_CHECKSUM_EN
  ,
  output logic                 chk_err
`endif
);

  typedef enum logic [2:0] {
    IDLE, LOAD, SORT_REQ, SORT_WAIT, DRAIN_RD, DRAIN_CAP, DRAIN_HOLD
  } state_e;

  state_e               state_q, state_d;
  logic [LEN_W-1:0]     k_q, k_d, len_q, len_d;
  logic [WORD_SIZE-1:0] base_q, base_d, out_data_q, out_data_d;
  logic                 err_len_q, err_len_d;
  logic                 len_ok, cmd_accept, in_fire, out_fire, k_last;
  logic [WORD_SIZE-1:0] addr_k;

  assign len_ok     = (len != '0) && (len <= LEN_W'(MAX_LEN));
  assign cmd_accept = (state_q == IDLE) && cmd_start && len_ok;
  assign in_fire    = (state_q == LOAD) && in_valid;
  assign out_fire   = (state_q == DRAIN_HOLD) && out_ready;
  assign k_last     = (k_q == len_q - LEN_W'(1));
  assign addr_k     = base_q + WORD_SIZE'(k_q);

  assign out_data = out_data_q;
  assign err_len  = err_len_q;
  assign busy     = (state_q != IDLE);
  assign sort_lo  = '0;

  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    len_d        = len_q;
    base_d       = base_q;
    out_data_d   = out_data_q;
    err_len_d    = 1'b0;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    out_last     = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    mem_read_en  = 1'b0;
    mem_write_en = 1'b0;
    mem_owner    = 1'b0;
    sort_start   = 1'b0;
    sort_hi      = '0;
    unique case (state_q)
      IDLE: begin
        if (cmd_accept) begin
          base_d  = base_addr;
          len_d   = len;
          k_d     = '0;
          state_d = LOAD;
        end else if (cmd_start) begin
          err_len_d = 1'b1;
        end
      end
      LOAD: begin
        in_ready = 1'b1;
        if (in_fire) begin
          mem_write_en = 1'b1;
          mem_addr     = addr_k;
          mem_wdata    = in_data;
          if (k_last) begin
            k_d     = '0;
            // A single element is already sorted, so skip the engine entirely.
            state_d = (len_q == LEN_W'(1)) ? DRAIN_RD : SORT_REQ;
          end else begin
            k_d = k_q + LEN_W'(1);
          end
        end
      end
      SORT_REQ: begin
        mem_owner  = 1'b1;
        sort_start = 1'b1;
        sort_hi    = WORD_SIZE'(len_q - LEN_W'(1));
        state_d    = SORT_WAIT;
      end
      SORT_WAIT: begin
        mem_owner = 1'b1;
        sort_hi   = WORD_SIZE'(len_q - LEN_W'(1));
        if (sort_done) state_d = DRAIN_RD;
      end
      DRAIN_RD: begin
        mem_read_en = 1'b1;
        mem_addr    = addr_k;
        state_d     = DRAIN_CAP;
      end
      DRAIN_CAP: begin
        out_data_d = mem_rdata;
        state_d    = DRAIN_HOLD;
      end
      DRAIN_HOLD: begin
        out_valid = 1'b1;
        out_last  = k_last;
        if (out_fire) begin
          if (k_last) begin
            k_d     = '0;
            state_d = IDLE;
          end else begin
            k_d     = k_q + LEN_W'(1);
            state_d = DRAIN_RD;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      k_q        <= '0;
      len_q      <= '0;
      base_q     <= '0;
      out_data_q <= '0;
      err_len_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      len_q      <= len_d;
      base_q     <= base_d;
      out_data_q <= out_data_d;
      err_len_q  <= err_len_d;
    end
  end

`ifdef QS_IO_CHECKSUM_EN
  logic [WORD_SIZE-1:0] load_sum_q, load_sum_d, drain_sum_q, drain_sum_d;
  logic                 chk_err_q, chk_err_d;

  assign chk_err = chk_err_q;

  // The final word is folded in at compare time since drain_sum only updates at the edge.
  always_comb begin
    load_sum_d  = load_sum_q;
    drain_sum_d = drain_sum_q;
    chk_err_d   = chk_err_q;
    if (cmd_accept) begin
      load_sum_d  = '0;
      drain_sum_d = '0;
      chk_err_d   = 1'b0;
    end
    if (in_fire) load_sum_d = load_sum_q + in_data;
    if (out_fire) begin
      drain_sum_d = drain_sum_q + out_data_q;
      if (k_last) chk_err_d = chk_err_q | (load_sum_q != (drain_sum_q + out_data_q));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      load_sum_q  <= '0;
      drain_sum_q <= '0;
      chk_err_q   <= 1'b0;
    end else begin
      load_sum_q  <= load_sum_d;
      drain_sum_q <= drain_sum_d;
      chk_err_q   <= chk_err_d;
    end
  end
`endif

endmodule

// File: tb/tb_quick_sort_io_sequencer.sv
// Self-checking bench: register-file model, emulated sort controller and a
// sorted-list reference model driven with randomized arrays.
module tb_quick_sort_io_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_start;
  logic [15:0] base_addr;
  logic [5:0]  len;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_read_en;
  logic        mem_write_en;
  logic        mem_owner;
  logic        sort_start;
  logic [15:0] sort_lo;
  logic [15:0] sort_hi;
  logic        sort_done;
  logic        busy;
  logic        err_len;
`ifdef QS_IO_CHECKSUM_EN
  logic        chk_err;
`endif

  int checks = 0;
  int errors = 0;

  logic [15:0] mem [0:65535];
  logic        sort_we;
  logic [15:0] sort_waddr;
  logic [15:0] sort_wdata;
  logic        corrupt_en;
  logic [15:0] corrupt_addr;

  logic [15:0] in_vals  [0:31];
  logic [15:0] buf_vals [0:31];
  logic [15:0] exp_vals [0:31];

  quick_sort_io_sequencer dut (
    .clk(clk), .reset(reset), .cmd_start(cmd_start), .base_addr(base_addr), .len(len),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_read_en(mem_read_en), .mem_write_en(mem_write_en), .mem_owner(mem_owner),
    .sort_start(sort_start), .sort_lo(sort_lo), .sort_hi(sort_hi), .sort_done(sort_done),
    .busy(busy), .err_len(err_len)
`ifdef QS_IO_CHECKSUM_EN
    , .chk_err(chk_err)
`endif
  );

  always #5 clk = ~clk;

  // Register file behind the external port mux selected by mem_owner.
  always @(posedge clk) begin
    if (mem_owner) begin
      if (sort_we) mem[sort_waddr] <= sort_wdata;
    end else begin
      if (mem_write_en) mem[mem_addr] <= mem_wdata;
      if (mem_read_en)
        mem_rdata <= mem[mem_addr] ^ ((corrupt_en && mem_addr == corrupt_addr) ? 16'h0100 : 16'h0000);
    end
  end

  task automatic sort_buf(input int n);
    logic [15:0] t;
    int j;
    for (int i = 1; i < n; i++) begin
      t = buf_vals[i];
      j = i - 1;
      while (j >= 0 && buf_vals[j] > t) begin
        buf_vals[j+1] = buf_vals[j];
        j--;
      end
      buf_vals[j+1] = t;
    end
  endtask

  task automatic run_job(input logic [15:0] base, input int n, input int stall_word,
                         input bit gaps, input bit poke_cmd, input int corrupt_idx);
    int cnt;
    logic [15:0] a;
    for (int i = 0; i < n; i++) buf_vals[i] = in_vals[i];
    sort_buf(n);
    for (int i = 0; i < n; i++) exp_vals[i] = buf_vals[i];
    if (corrupt_idx >= 0) begin
      exp_vals[corrupt_idx] = exp_vals[corrupt_idx] ^ 16'h0100;
      corrupt_addr = base + 16'(corrupt_idx);
      corrupt_en = 1'b1;
    end else begin
      corrupt_en = 1'b0;
    end

    @(negedge clk);
    cmd_start = 1'b1; base_addr = base; len = 6'(n);
    @(negedge clk);
    cmd_start = 1'b0;
    #1;
    checks++;
    if ({busy, in_ready, err_len} !== 3'b110)
      begin errors++; $display("[TB] FAIL job_start: {busy,in_ready,err_len}=%b expected 110", {busy, in_ready, err_len}); end
`ifdef QS_IO_CHECKSUM_EN
    checks++;
    if (chk_err !== 1'b0)
      begin errors++; $display("[TB] FAIL chk_clear_on_start: got %b expected 0", chk_err); end
`endif

    for (int i = 0; i < n; i++) begin
      if (gaps && ($urandom % 4 == 0)) begin
        in_valid = 1'b0;
        #1;
        checks++;
        if (mem_write_en !== 1'b0)
          begin errors++; $display("[TB] FAIL load_gap: mem_write_en=%b expected 0", mem_write_en); end
        @(negedge clk);
      end
      in_valid = 1'b1; in_data = in_vals[i];
      #1;
      a = base + 16'(i);
      checks++;
      if ({mem_write_en, in_ready, mem_addr, mem_wdata} !== {1'b1, 1'b1, a, in_vals[i]})
        begin errors++; $display("[TB] FAIL load_write[%0d]: we=%b rdy=%b addr=%h data=%h expected 1 1 %h %h",
                                 i, mem_write_en, in_ready, mem_addr, mem_wdata, a, in_vals[i]); end
      @(negedge clk);
    end
    in_valid = 1'b0;
    #1;

    if (n > 1) begin
      cnt = 0;
      while (sort_start !== 1'b1 && cnt < 4) begin @(negedge clk); #1; cnt++; end
      checks++;
      if ({cnt == 0, sort_start, mem_owner, sort_lo, sort_hi, in_ready} !== {1'b1, 1'b1, 1'b1, 16'h0, 16'(n - 1), 1'b0})
        begin errors++; $display("[TB] FAIL sort_req: delay=%0d start=%b owner=%b lo=%h hi=%h in_ready=%b expected 0 1 1 0000 %h 0",
                                 cnt, sort_start, mem_owner, sort_lo, sort_hi, in_ready, 16'(n - 1)); end
      @(negedge clk); #1;
      checks++;
      if ({sort_start, mem_owner, mem_write_en, mem_read_en} !== 4'b0100)
        begin errors++; $display("[TB] FAIL sort_wait: {start,owner,we,re}=%b expected 0100", {sort_start, mem_owner, mem_write_en, mem_read_en}); end
      if (poke_cmd) begin
        cmd_start = 1'b1; base_addr = base ^ 16'h5555; len = 6'd5;
        @(negedge clk);
        cmd_start = 1'b0;
        #1;
        checks++;
        if ({err_len, busy, mem_owner} !== 3'b011)
          begin errors++; $display("[TB] FAIL cmd_in_sort_wait: {err_len,busy,owner}=%b expected 011", {err_len, busy, mem_owner}); end
      end
      // Emulated sort controller: sort the stored range through its own port.
      for (int i = 0; i < n; i++) begin a = base + 16'(i); buf_vals[i] = mem[a]; end
      sort_buf(n);
      for (int i = 0; i < n; i++) begin
        sort_we = 1'b1; sort_waddr = base + 16'(i); sort_wdata = buf_vals[i];
        @(negedge clk);
      end
      sort_we = 1'b0;
      #1;
      checks++;
      if ({mem_owner, busy} !== 2'b11)
        begin errors++; $display("[TB] FAIL owner_hold: {owner,busy}=%b expected 11", {mem_owner, busy}); end
      sort_done = 1'b1;
      @(negedge clk);
      sort_done = 1'b0;
      #1;
    end
    checks++;
    if ({mem_owner, sort_start, mem_read_en, mem_addr} !== {1'b0, 1'b0, 1'b1, base})
      begin errors++; $display("[TB] FAIL drain_first_read: owner=%b start=%b re=%b addr=%h expected 0 0 1 %h",
                               mem_owner, sort_start, mem_read_en, mem_addr, base); end

    for (int j = 0; j < n; j++) begin
      if (j == stall_word) out_ready = 1'b0;
      cnt = 0;
      while (out_valid !== 1'b1 && cnt < 8) begin @(negedge clk); #1; cnt++; end
      checks++;
      if (out_valid !== 1'b1) begin
        errors++; $display("[TB] FAIL drain_timeout[%0d]: out_valid=%b expected 1", j, out_valid);
        out_ready = 1'b1;
        break;
      end
      checks++;
      if ({out_data, out_last} !== {exp_vals[j], j == n - 1})
        begin errors++; $display("[TB] FAIL drain_word[%0d]: data=%h last=%b expected %h %b", j, out_data, out_last, exp_vals[j], j == n - 1); end
      if (j == stall_word) begin
        for (int s = 0; s < 5; s++) begin
          @(negedge clk); #1;
          checks++;
          if ({out_valid, out_last, out_data, mem_read_en} !== {1'b1, j == n - 1, exp_vals[j], 1'b0})
            begin errors++; $display("[TB] FAIL drain_stall[%0d]: valid=%b last=%b data=%h re=%b expected 1 %b %h 0",
                                     s, out_valid, out_last, out_data, mem_read_en, j == n - 1, exp_vals[j]); end
        end
        out_ready = 1'b1;
      end
      @(negedge clk); #1;
    end
    checks++;
    if ({busy, out_valid, out_last} !== 3'b000)
      begin errors++; $display("[TB] FAIL job_end: {busy,valid,last}=%b expected 000", {busy, out_valid, out_last}); end
`ifdef QS_IO_CHECKSUM_EN
    checks++;
    if (chk_err !== (corrupt_idx >= 0))
      begin errors++; $display("[TB] FAIL chk_err: got %b expected %b", chk_err, corrupt_idx >= 0); end
`endif
    corrupt_en = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({busy, in_ready, out_valid, out_last, mem_read_en, mem_write_en, mem_owner, sort_start, err_len} !== 9'b0)
      begin errors++; $display("[TB] FAIL reset_ctrl: got %b expected 000000000",
                               {busy, in_ready, out_valid, out_last, mem_read_en, mem_write_en, mem_owner, sort_start, err_len}); end
    checks++;
    if ({out_data, mem_addr, mem_wdata, sort_hi} !== 64'h0)
      begin errors++; $display("[TB] FAIL reset_data: out=%h addr=%h wdata=%h hi=%h expected 0", out_data, mem_addr, mem_wdata, sort_hi); end
`ifdef QS_IO_CHECKSUM_EN
    checks++;
    if (chk_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_chk: got %b expected 0", chk_err); end
`endif
    reset = 1'b1;
  endtask

  task automatic test_err_len;
    logic [5:0] bad [0:2];
    bad[0] = 6'd0; bad[1] = 6'd33; bad[2] = 6'd63;
    for (int b = 0; b < 3; b++) begin
      @(negedge clk);
      cmd_start = 1'b1; len = bad[b]; base_addr = 16'($urandom);
      @(negedge clk);
      cmd_start = 1'b0;
      #1;
      checks++;
      if ({err_len, busy, in_ready} !== 3'b100)
        begin errors++; $display("[TB] FAIL err_len_pulse(len=%0d): {err,busy,rdy}=%b expected 100", bad[b], {err_len, busy, in_ready}); end
      @(negedge clk); #1;
      checks++;
      if ({err_len, busy} !== 2'b00)
        begin errors++; $display("[TB] FAIL err_len_width(len=%0d): {err,busy}=%b expected 00", bad[b], {err_len, busy}); end
    end
  endtask

  task automatic test_reset_mid_load;
    @(negedge clk);
    cmd_start = 1'b1; base_addr = 16'h0200; len = 6'd8;
    @(negedge clk);
    cmd_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 16'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({busy, in_ready, mem_write_en, mem_owner} !== 4'b0000)
      begin errors++; $display("[TB] FAIL reset_mid_load: {busy,rdy,we,owner}=%b expected 0000", {busy, in_ready, mem_write_en, mem_owner}); end
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 8; i++) in_vals[i] = 16'($urandom);
    run_job(16'h0200, 8, -1, 1'b0, 1'b0, -1);
  endtask

  task automatic test_basic;
    in_vals[0] = 16'd9; in_vals[1] = 16'd3; in_vals[2] = 16'd7; in_vals[3] = 16'd1;
    run_job(16'h0010, 4, -1, 1'b0, 1'b0, -1);
  endtask

  task automatic test_stall;
    for (int i = 0; i < 6; i++) in_vals[i] = 16'($urandom);
    run_job(16'($urandom), 6, 2, 1'b0, 1'b0, -1);
  endtask

  task automatic test_len_one;
    in_vals[0] = 16'd42;
    run_job(16'h0777, 1, 0, 1'b0, 1'b0, -1);
  endtask

  task automatic test_cmd_in_sort_wait;
    for (int i = 0; i < 5; i++) in_vals[i] = 16'($urandom);
    run_job(16'h1000, 5, -1, 1'b0, 1'b1, -1);
  endtask

  task automatic test_random;
    int n;
    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(2, 32);
      for (int i = 0; i < n; i++) in_vals[i] = 16'($urandom_range(0, 15));
      if (r == 0) run_job(16'hFFF0, 32, -1, 1'b1, 1'b0, -1);
      else run_job(16'($urandom), n, $urandom_range(0, n - 1), 1'b1, 1'b0, -1);
    end
  endtask

`ifdef QS_IO_CHECKSUM_EN
  task automatic test_checksum;
    for (int i = 0; i < 6; i++) in_vals[i] = 16'($urandom);
    run_job(16'h3000, 6, -1, 1'b0, 1'b0, 3);
    for (int i = 0; i < 6; i++) in_vals[i] = 16'($urandom);
    run_job(16'h3100, 6, -1, 1'b0, 1'b0, -1);
  endtask
`endif

  initial begin
    reset = 1'b0; cmd_start = 1'b0; base_addr = '0; len = '0;
    in_data = '0; in_valid = 1'b0; out_ready = 1'b1; sort_done = 1'b0;
    sort_we = 1'b0; sort_waddr = '0; sort_wdata = '0;
    corrupt_en = 1'b0; corrupt_addr = '0; mem_rdata = '0;
    test_reset;
    test_basic;
    test_stall;
    test_len_one;
    test_err_len;
    test_cmd_in_sort_wait;
    test_reset_mid_load;
    test_random;
`ifdef QS_IO_CHECKSUM_EN
    test_checksum;
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
